instr_fetch_unit: RTL

//  Fetch stage feeding the decode/immediate-generation logic. Owns the PC register and issues

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/instr_fetch_unit_sync_fifo.sv | 53 +++++
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: reset PC default,
// fetch FSM encoding, canonical NOP and a word-alignment helper.
package instr_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // state | meaning
    // RUN   | normal fetch, requests issued while credit remains
    // FLUSH | waiting for stale in-flight responses to retire, no requests
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_sync_fifo.sv
// Small synchronous FIFO with a synchronous clear; head is read combinationally.
// Clear has priority over a same-cycle push or pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // Storage; cleared on reset so the head reads as zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_push && !i_clr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads with a credit limit of
// FIFO_DEPTH (in-flight + buffered), buffers {pc, word} and discards
// responses that belong to requests issued before a redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign_err
);
    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(FIFO_DEPTH);

    logic [0:0]    r_state;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_stale;
    logic          r_misalign;

    logic [CW-1:0] w_inflight;
    logic [CW-1:0] w_fifo_count;
    logic [CW-1:0] w_inflight_next;
    logic [CW:0]   w_outstanding;
    logic          w_accept;
    logic          w_pop;
    logic          w_rsp_keep;
    logic [31:0]   w_rsp_pc;
    logic [63:0]   w_head;

    // A same-cycle pop does not return credit; rst_n gating keeps the request low during reset
    assign w_outstanding   = {1'b0, w_inflight} + {1'b0, w_fifo_count};
    assign imem_req_valid  = rst_n && (r_state == ST_RUN) && (w_outstanding < DEPTH_L);
    assign imem_req_addr   = r_fetch_pc;
    assign w_accept        = imem_req_valid && imem_req_ready;
    assign w_inflight_next = w_inflight + CW'(w_accept) - CW'(imem_rsp_valid);
    assign w_rsp_keep      = imem_rsp_valid && (r_stale == '0);
    assign w_pop           = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid  = (w_fifo_count != '0);
    assign instr_pc     = w_head[63:32];
    assign instr        = w_head[31:0];
    assign misalign_err = r_misalign;

    // PC register: redirect wins over sequential advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= word_align(redirect_pc);
        end else if (w_accept) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    // RUN/FLUSH control and stale-response accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_stale <= '0;
        end else if (redirect_valid) begin
            r_stale <= w_inflight_next;
            r_state <= (w_inflight_next != '0) ? ST_FLUSH : ST_RUN;
        end else if (imem_rsp_valid && (r_stale != '0)) begin
            r_stale <= r_stale - CW'(1);
            if (r_stale == CW'(1)) r_state <= ST_RUN;
        end
    end

    // One-cycle pulse for a redirect target that is not word aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    // PCs of accepted requests, retired in order as responses return (stale ones included)
    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (1'b0),
        .i_push  (w_accept),
        .i_data  (r_fetch_pc),
        .i_pop   (imem_rsp_valid),
        .o_head  (w_rsp_pc),
        .o_count (w_inflight)
    );

    // Delivered {pc, word} buffer, flushed on redirect
    sync_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (redirect_valid),
        .i_push  (w_rsp_keep),
        .i_data  ({w_rsp_pc, imem_rsp_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count)
    );

endmodule
